// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared widths, pipeline state type and one bit-pair square-root iteration.
package isqrt_pkg;
    localparam int ISQRT_W = 32;
    localparam int ISQRT_ITER = 16;

    typedef struct packed {
        logic [ISQRT_W-1:0] op;
        logic [ISQRT_W-1:0] res;
    } isqrt_state_t;

    // res + one cannot overflow: res < 2^17 and one <= 2^30 at every step.
    function automatic isqrt_state_t isqrt_step(isqrt_state_t s, int k);
        logic [ISQRT_W-1:0] one;
        logic [ISQRT_W-1:0] sum;
        isqrt_state_t n;
        one = ISQRT_W'(1) << (2 * k);
        sum = s.res + one;
        n.op = (s.op >= sum) ? s.op - sum : s.op;
        n.res = (s.op >= sum) ? (s.res >> 1) + one : s.res >> 1;
        return n;
    endfunction
endpackage

// File: rtl/isqrt_pipe_stage.sv
// isqrt_pipe_stage: N_ITER combinational iterations starting at FIRST_K, then a register
// whose data only loads on valid so bubbles cause no data toggling.
module isqrt_pipe_stage
    import isqrt_pkg::*;
#(
    parameter int FIRST_K = 15,
    parameter int N_ITER = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vld,
    input  logic [31:0] i_op,
    input  logic [31:0] i_res,
    output logic        o_vld,
    output logic [31:0] o_op,
    output logic [31:0] o_res
);
    isqrt_state_t w_st;
    logic r_vld;
    logic [31:0] r_op;
    logic [31:0] r_res;

    always_comb begin
        w_st = '{op: i_op, res: i_res};
        for (int j = 0; j < N_ITER; j++) w_st = isqrt_step(w_st, FIRST_K - j);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_op <= '0;
            r_res <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_op <= w_st.op;
                r_res <= w_st.res;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_op = r_op;
    assign o_res = r_res;
endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined y = floor(sqrt(x)), one operand per clock,
// latency n_pipe_stages cycles, no backpressure.
module isqrt_pipe
    import isqrt_pkg::*;
#(
    parameter int n_pipe_stages = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [31:0] y
);
    localparam int IPS = ISQRT_ITER / n_pipe_stages;

    if (!(n_pipe_stages == 1 || n_pipe_stages == 2 || n_pipe_stages == 4 ||
          n_pipe_stages == 8 || n_pipe_stages == 16)) begin : g_bad
        $error("isqrt_pipe: n_pipe_stages must be 1, 2, 4, 8 or 16");
    end

    logic        w_vld [n_pipe_stages+1];
    logic [31:0] w_op  [n_pipe_stages+1];
    logic [31:0] w_res [n_pipe_stages+1];

    assign w_vld[0] = x_vld;
    assign w_op[0] = x;
    assign w_res[0] = '0;

    for (genvar s = 0; s < n_pipe_stages; s++) begin : g_st
        isqrt_pipe_stage #(
            .FIRST_K(ISQRT_ITER - 1 - s * IPS),
            .N_ITER(IPS)
        ) u_st (
            .clk(clk),
            .rst(rst),
            .i_vld(w_vld[s]),
            .i_op(w_op[s]),
            .i_res(w_res[s]),
            .o_vld(w_vld[s+1]),
            .o_op(w_op[s+1]),
            .o_res(w_res[s+1])
        );
    end

    assign y_vld = w_vld[n_pipe_stages];
    assign y = w_res[n_pipe_stages];
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: three pipeline depths (1, 4, 16) share one stimulus stream,
// each with its own scoreboard of expected result and due cycle.
module tb_isqrt_pipe;
    typedef struct packed {
        logic [31:0] y;
        int          due;
    } item_t;

    localparam int LAT [3] = '{1, 4, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x = '0;
    logic        y_vld_a [3];
    logic [31:0] y_a [3];
    logic [31:0] last [3];
    item_t       q [3][$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        gate = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    isqrt_pipe #(.n_pipe_stages(1)) d1 (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(y_vld_a[0]), .y(y_a[0]));
    isqrt_pipe #(.n_pipe_stages(4)) d4 (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(y_vld_a[1]), .y(y_a[1]));
    isqrt_pipe #(.n_pipe_stages(16)) d16 (.clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(y_vld_a[2]), .y(y_a[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] msqrt(input logic [31:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, v}) r = t;
        end
        return r[31:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] xv);
        @(posedge clk);
        #1;
        x_vld = v;
        x = xv;
        if (v) for (int i = 0; i < 3; i++) q[i].push_back(item_t'{y: msqrt(xv), due: cyc + LAT[i]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (y_vld_a[i]) begin
                if (q[i].size() == 0) chk($sformatf("spurious_vld%0d", LAT[i]), 32'(y_vld_a[i]), 32'd0);
                else begin
                    item_t it;
                    it = q[i].pop_front();
                    chk($sformatf("y%0d", LAT[i]), y_a[i], it.y);
                    chk($sformatf("lat%0d", LAT[i]), cyc, it.due);
                    last[i] = y_a[i];
                end
            end else chk($sformatf("hold%0d", LAT[i]), y_a[i], last[i]);
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_gate
        logic [31:0] p_op;
        logic [31:0] p_res;
        always @(negedge clk) begin
            if (gate) begin
                chk("gate_op", d16.g_st[g].u_st.r_op, p_op);
                chk("gate_res", d16.g_st[g].u_st.r_res, p_res);
            end
            p_op = d16.g_st[g].u_st.r_op;
            p_res = d16.g_st[g].u_st.r_res;
        end
    end

    initial begin
        logic [31:0] corners [6];
        corners = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF, 32'hFFFE_0001};
        for (int i = 0; i < 3; i++) last[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_vld", 32'(y_vld_a[i]), 32'd0);
            chk("rst_y", y_a[i], 32'd0);
        end
        foreach (corners[k]) begin
            drive(1'b1, corners[k]);
            idle(18);
        end
        for (int n = 0; n < 1000; n++) drive(1'b1, (n % 4 == 0) ? $urandom_range(0, 300) : $urandom);
        idle(20);
        drive(1'b1, 32'd100);
        idle(2);
        drive(1'b1, 32'd81);
        idle(1);
        drive(1'b1, 32'd2);
        idle(20);
        gate = 1'b1;
        idle(50);
        gate = 1'b0;
        drive(1'b1, 32'd400);
        drive(1'b1, 32'd900);
        drive(1'b1, 32'd12345);
        @(posedge clk);
        #1;
        rst = 1'b1;
        x_vld = 1'b1;
        x = 32'd77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        x_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            last[i] = '0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_vld", 32'(y_vld_a[i]), 32'd0);
            chk("midrst_y", y_a[i], 32'd0);
        end
        drive(1'b1, 32'd49);
        idle(20);
        for (int i = 0; i < 3; i++) chk("leftover", q[i].size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
